// File: rtl/aes_input_loader.sv
// rtl/aes_input_loader.sv - byte-serial framer that assembles key/message and commits them to the AES core
module aes_input_loader #(
   parameter int nk = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             core_busy,
   output logic [0:127]     Message,
   output logic [0:32*nk-1] Key,
   output logic             start,
   output logic             key_valid,
   output logic             err
);
   localparam int         KEY_BYTES = 4 * nk;
   localparam logic [5:0] KEY_LAST  = 6'(KEY_BYTES - 1);
   localparam logic [5:0] MSG_LAST  = 6'd15;
   localparam logic [7:0] HDR_K     = 8'h4B;
   localparam logic [7:0] HDR_M     = 8'h4D;

   typedef enum logic [1:0] {S_IDLE, S_KEY, S_MSG, S_WAIT} state_t;

   state_t           state;
   logic [5:0]       cnt;
   logic [0:127]     shadow_msg;
   logic [0:32*nk-1] shadow_key;
   logic             frame_k;
   logic             take;

   assign take = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         shadow_msg <= '0;
         shadow_key <= '0;
         frame_k    <= 1'b0;
         Message    <= '0;
         Key        <= '0;
         start      <= 1'b0;
         err        <= 1'b0;
         key_valid  <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         start <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (take) begin
                  if (in_byte == HDR_K) begin
                     state   <= S_KEY;
                     cnt     <= '0;
                     frame_k <= 1'b1;
                  end else if (in_byte == HDR_M && key_valid) begin
                     state   <= S_MSG;
                     cnt     <= '0;
                     frame_k <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_KEY: begin
               if (take) begin
                  // Byte i of the field occupies bits [8i:8i+7], so the first byte is the MSB.
                  for (int i = 0; i < KEY_BYTES; i++) begin
                     if (cnt == 6'(i)) shadow_key[8*i +: 8] <= in_byte;
                  end
                  if (cnt == KEY_LAST) begin
                     state <= S_MSG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            S_MSG: begin
               if (take) begin
                  for (int i = 0; i < 16; i++) begin
                     if (cnt == 6'(i)) shadow_msg[8*i +: 8] <= in_byte;
                  end
                  if (cnt == MSG_LAST) begin
                     state    <= S_WAIT;
                     cnt      <= '0;
                     in_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            S_WAIT: begin
               // Commit key and message together so the core never sees a mixed pair.
               if (!core_busy) begin
                  Message <= shadow_msg;
                  if (frame_k) begin
                     Key       <= shadow_key;
                     key_valid <= 1'b1;
                  end
                  start    <= 1'b1;
                  state    <= S_IDLE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_input_loader.sv
// tb/tb_aes_input_loader.sv - randomized frame-level model check of aes_input_loader
module tb_aes_input_loader;
   localparam int NK = 8;
   localparam int KB = 4 * NK;
   localparam logic [255:0] K_LIT  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] M_LIT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] M2_LIT = 128'hffeeddccbbaa99887766554433221100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] in_byte = 8'h00;
   logic in_valid = 1'b0;
   logic in_ready;
   logic busy_hold = 1'b0;
   logic busy_rnd = 1'b0;
   logic core_busy;
   logic [0:127] Message;
   logic [0:32*NK-1] Key;
   logic start, key_valid, err;

   assign core_busy = busy_hold | busy_rnd;

   aes_input_loader #(.nk(NK)) dut (
      .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .core_busy(core_busy), .Message(Message), .Key(Key), .start(start),
      .key_valid(key_valid), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Frame-level reference: collected data bytes, frame length, and the committed outputs.
   logic [7:0] m_data[$];
   bit m_in_frame, m_is_k, m_waiting;
   int m_need;
   logic [0:127] exp_msg;
   logic [0:32*NK-1] exp_key;
   bit exp_start, exp_err, exp_kv, exp_ready;
   int m_accepted = 0, m_hdr_cyc = 0, m_commits = 0, m_errs = 0;

   bit checking = 0;
   bit rnd_busy_en = 0;
   int dut_start_cyc = 0, dut_starts = 0, dut_errs = 0;

   logic [7:0] fkey[KB];
   logic [7:0] fmsg[16];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_data.delete();
         m_in_frame = 0; m_is_k = 0; m_waiting = 0; m_need = 0;
         exp_msg = '0; exp_key = '0;
         exp_start = 0; exp_err = 0; exp_kv = 0; exp_ready = 1;
      end else begin
         exp_start = 0;
         exp_err = 0;
         if (m_waiting) begin
            if (!core_busy) begin
               int off;
               off = m_is_k ? KB : 0;
               for (int i = 0; i < 16; i++) exp_msg[8*i +: 8] = m_data[off + i];
               if (m_is_k) begin
                  for (int i = 0; i < KB; i++) exp_key[8*i +: 8] = m_data[i];
                  exp_kv = 1;
               end
               exp_start = 1;
               m_commits++;
               m_waiting = 0;
               m_in_frame = 0;
               m_data.delete();
            end
         end else if (in_valid) begin
            m_accepted++;
            if (!m_in_frame) begin
               if (in_byte == 8'h4B) begin
                  m_in_frame = 1; m_is_k = 1; m_need = KB + 16; m_hdr_cyc = cyc;
               end else if (in_byte == 8'h4D && exp_kv) begin
                  m_in_frame = 1; m_is_k = 0; m_need = 16; m_hdr_cyc = cyc;
               end else begin
                  exp_err = 1;
                  m_errs++;
               end
            end else begin
               m_data.push_back(in_byte);
               if (m_data.size() == m_need) m_waiting = 1;
            end
         end
         exp_ready = !m_waiting;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready", 256'(in_ready), 256'(exp_ready));
         chk("start", 256'(start), 256'(exp_start));
         chk("err", 256'(err), 256'(exp_err));
         chk("key_valid", 256'(key_valid), 256'(exp_kv));
         chk("Message", 256'(Message), 256'(exp_msg));
         chk("Key", 256'(Key), 256'(exp_key));
         if (start === 1'b1) begin dut_start_cyc = cyc; dut_starts++; end
         if (err === 1'b1) dut_errs++;
      end
   end

   always @(negedge clk) busy_rnd <= rnd_busy_en && ($urandom_range(3) == 0);

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      int acc0;
      in_valid = 1'b0;
      for (int g = 0; g < 6 && $urandom_range(99) < gap; g++) @(negedge clk);
      in_byte = b;
      in_valid = 1'b1;
      acc0 = m_accepted;
      n = 0;
      do begin @(negedge clk); n++; end while (m_accepted == acc0 && n < 300);
      in_valid = 1'b0;
      checks++;
      if (m_accepted == acc0) begin
         errors++;
         $display("FAIL byte_timeout: byte %h not accepted after %0d cycles, required accepted", b, n);
      end
   endtask

   task automatic send_frame(input bit is_k, input int gap);
      send_byte(is_k ? 8'h4B : 8'h4D, gap);
      if (is_k) for (int i = 0; i < KB; i++) send_byte(fkey[i], gap);
      for (int i = 0; i < 16; i++) send_byte(fmsg[i], gap);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_in_frame || m_waiting) && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL commit_timeout: frame still pending after %0d cycles, required committed", n);
      end
      @(negedge clk);
   endtask

   task automatic load_vectors(input logic [255:0] k, input logic [127:0] m);
      for (int i = 0; i < KB; i++) fkey[i] = k[255 - 8*i -: 8];
      for (int i = 0; i < 16; i++) fmsg[i] = m[127 - 8*i -: 8];
   endtask

   task automatic load_random();
      for (int i = 0; i < KB; i++) fkey[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) fmsg[i] = 8'($urandom);
   endtask

   initial begin
      int e0, s0, expect_cyc, acc0;
      logic [255:0] rk;
      rst = 1'b1;
      @(negedge clk);
      checking = 1;
      @(negedge clk);
      chk("reset_Message", 256'(Message), 256'd0);
      chk("reset_Key", 256'(Key), 256'd0);
      chk("reset_key_valid", 256'(key_valid), 256'd0);
      chk("reset_in_ready", 256'(in_ready), 256'd1);
      rst = 1'b0;

      // Known-answer K frame, no gaps, core idle.
      load_vectors(K_LIT, M_LIT);
      send_frame(1, 0);
      wait_idle();
      chk("kat_Key", 256'(Key), K_LIT);
      chk("kat_Message", 256'(Message), 256'(M_LIT));
      chk("kat_key_valid", 256'(key_valid), 256'd1);
      chk("kat_start_latency", 256'(dut_start_cyc - m_hdr_cyc), 256'd49);

      // M frame reuses the committed key.
      load_vectors(K_LIT, M2_LIT);
      send_frame(0, 0);
      wait_idle();
      chk("m_Message", 256'(Message), 256'(M2_LIT));
      chk("m_Key_kept", 256'(Key), K_LIT);
      chk("m_start_latency", 256'(dut_start_cyc - m_hdr_cyc), 256'd17);

      // M header with no key committed is rejected.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      e0 = dut_errs;
      send_byte(8'h4D, 0);
      @(negedge clk);
      chk("nokey_err_count", 256'(dut_errs - e0), 256'd1);
      chk("nokey_Message", 256'(Message), 256'd0);
      chk("nokey_Key", 256'(Key), 256'd0);
      load_random();
      send_frame(1, 0);
      wait_idle();
      chk("after_err_key_valid", 256'(key_valid), 256'd1);

      // Core busy holds the commit; the loader refuses bytes meanwhile.
      busy_hold = 1'b1;
      load_random();
      send_frame(1, 0);
      s0 = dut_starts;
      for (int i = 0; i < 10; i++) begin
         in_byte = 8'h4B;
         in_valid = i[0];
         @(negedge clk);
         chk("busy_in_ready", 256'(in_ready), 256'd0);
      end
      in_valid = 1'b0;
      chk("busy_no_start", 256'(dut_starts - s0), 256'd0);
      busy_hold = 1'b0;
      expect_cyc = cyc + 1;
      wait_idle();
      chk("busy_release_start", 256'(dut_start_cyc), 256'(expect_cyc));

      // Gapped K frame must give the same result as the gap-free one.
      load_vectors(K_LIT, M_LIT);
      send_frame(1, 60);
      wait_idle();
      chk("gap_Key", 256'(Key), K_LIT);
      chk("gap_Message", 256'(Message), 256'(M_LIT));

      // Reset after ten key bytes discards everything.
      load_random();
      send_byte(8'h4B, 0);
      for (int i = 0; i < 10; i++) send_byte(fkey[i], 0);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("midrst_Message", 256'(Message), 256'd0);
      chk("midrst_Key", 256'(Key), 256'd0);
      chk("midrst_key_valid", 256'(key_valid), 256'd0);
      load_random();
      for (int i = 0; i < KB; i++) rk[255 - 8*i -: 8] = fkey[i];
      send_frame(1, 20);
      wait_idle();
      chk("midrst_new_Key", 256'(Key), rk);

      // Randomized mix of K, M and bad headers with random gaps and core stalls.
      rnd_busy_en = 1;
      for (int f = 0; f < 30; f++) begin
         int kind;
         logic [7:0] b;
         kind = $urandom_range(9);
         load_random();
         if (kind < 4) send_frame(1, $urandom_range(50));
         else if (kind < 8) send_frame(0, $urandom_range(50));
         else begin
            b = 8'($urandom);
            if (b == 8'h4B || b == 8'h4D) b = 8'h00;
            send_byte(b, 0);
         end
         wait_idle();
      end
      rnd_busy_en = 0;
      @(negedge clk);
      @(negedge clk);
      chk("total_starts", 256'(dut_starts), 256'(m_commits));
      chk("total_errs", 256'(dut_errs), 256'(m_errs));
      acc0 = m_accepted;
      checking = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish, required finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end
endmodule
